// File: rtl/ucsbece154b_imem_burst.sv
// Instruction-side backing memory: accepts one block read, waits T0_DELAY cycles, then streams
// BLOCK_WORDS words on consecutive cycles. Define CRITICAL_WORD_FIRST_EN to start at the requested word.
module ucsbece154b_imem_burst #(
    parameter int unsigned T0_DELAY    = 40,
    parameter int unsigned BLOCK_WORDS = 4,
    parameter int unsigned MEM_WORDS   = 1024,
    parameter logic [31:0] TEXT_BASE   = 32'h0001_0000,
    parameter              MEM_FILE    = "text.dat"
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           ReadRequest,
    input  logic [31:0]                    ReadAddress,
    output logic                           Busy,
    output logic                           DataReady,
    output logic [31:0]                    DataIn,
    output logic [$clog2(BLOCK_WORDS)-1:0] WordOffset
);

    localparam int unsigned OFF_W = $clog2(BLOCK_WORDS);
    localparam int unsigned AW    = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam int unsigned DLY_W = (T0_DELAY > 1) ? $clog2(T0_DELAY) : 1;
    localparam logic [DLY_W-1:0] DLY_LOAD   = DLY_W'(T0_DELAY - 1);
    localparam logic [OFF_W-1:0] LAST_BURST = OFF_W'(BLOCK_WORDS - 1);
    // The image named by MEM_FILE is preloaded into mem by the simulation environment.
    localparam int unsigned unused_mem_file_bits = $bits(MEM_FILE);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_BURST} state_e;

    state_e           state_q, state_d;
    logic [DLY_W-1:0] dly_q, dly_d;
    logic [OFF_W-1:0] burst_q, burst_d;
    logic [31:0]      base_q, base_d;
`ifdef CRITICAL_WORD_FIRST_EN
    logic [OFF_W-1:0] req_off_q, req_off_d;
`endif

    // NOTE: the backing store has no reset; its contents must survive reset, and a memory array
    // with a reset cannot map onto RAM.
    logic [31:0] mem [MEM_WORDS];

    logic [OFF_W-1:0] word_off;
    logic [31:0]      word_addr;
    logic [31:0]      rel_addr;
    logic             in_range;
    logic             unused_addr_bits;

    // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            dly_q   <= '0;
            burst_q <= '0;
            base_q  <= '0;
`ifdef CRITICAL_WORD_FIRST_EN
            req_off_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            dly_q   <= dly_d;
            burst_q <= burst_d;
            base_q  <= base_d;
`ifdef CRITICAL_WORD_FIRST_EN
            req_off_q <= req_off_d;
`endif
        end
    end

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        dly_d   = dly_q;
        burst_d = burst_q;
        base_d  = base_q;
`ifdef CRITICAL_WORD_FIRST_EN
        req_off_d = req_off_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (ReadRequest) begin
                    state_d = S_WAIT;
                    dly_d   = DLY_LOAD;
                    base_d  = {ReadAddress[31:OFF_W+2], {(OFF_W+2){1'b0}}};
`ifdef CRITICAL_WORD_FIRST_EN
                    req_off_d = ReadAddress[OFF_W+1:2];
`endif
                end
            end
            S_WAIT: begin
                if (dly_q == '0) begin
                    state_d = S_BURST;
                    burst_d = '0;
                end else begin
                    dly_d = dly_q - 1'b1;
                end
            end
            S_BURST: begin
                burst_d = burst_q + 1'b1;
                if (burst_q == LAST_BURST) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

`ifdef CRITICAL_WORD_FIRST_EN
    assign unused_addr_bits = ^ReadAddress[1:0];
`else
    assign unused_addr_bits = ^ReadAddress[OFF_W+1:0];
`endif

    // Offset arithmetic wraps naturally in OFF_W bits, giving the modulo-BLOCK_WORDS order.
    always_comb begin
`ifdef CRITICAL_WORD_FIRST_EN
        word_off = burst_q + req_off_q;
`else
        word_off = burst_q;
`endif
        word_addr = base_q | {{(30-OFF_W){1'b0}}, word_off, 2'b00};
        rel_addr  = word_addr - TEXT_BASE;
        in_range  = (word_addr >= TEXT_BASE) && ((rel_addr >> 2) < MEM_WORDS);
    end

    always_comb begin
        Busy       = (state_q != S_IDLE);
        DataReady  = 1'b0;
        DataIn     = '0;
        WordOffset = '0;
        if (state_q == S_BURST) begin
            DataReady  = 1'b1;
            WordOffset = word_off;
            if (in_range) DataIn = mem[rel_addr[AW+1:2]];
        end
    end

endmodule

// File: tb/tb_ucsbece154b_imem_burst.sv
// Self-checking bench for ucsbece154b_imem_burst: randomized block requests compared against a
// cycle-level reference model of the block-read timing and address map.
module tb_ucsbece154b_imem_burst;

    localparam int unsigned T0   = 4;
    localparam int unsigned BW   = 4;
    localparam int unsigned MW   = 1024;
    localparam logic [31:0] BASE = 32'h0001_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        ReadRequest;
    logic [31:0] ReadAddress;
    logic        Busy;
    logic        DataReady;
    logic [31:0] DataIn;
    logic [1:0]  WordOffset;

    int total = 0;
    int bad   = 0;

    ucsbece154b_imem_burst #(
        .T0_DELAY   (T0),
        .BLOCK_WORDS(BW),
        .MEM_WORDS  (MW),
        .TEXT_BASE  (BASE),
        .MEM_FILE   ("text.dat")
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .ReadRequest(ReadRequest),
        .ReadAddress(ReadAddress),
        .Busy       (Busy),
        .DataReady  (DataReady),
        .DataIn     (DataIn),
        .WordOffset (WordOffset)
    );

    always #5 clk = ~clk;

    // Reference address map: word at a byte address, or zero outside the backing store.
    function automatic logic [31:0] model_word(input logic [31:0] byte_addr);
        logic [31:0] idx;
        if (byte_addr < BASE) return 32'h0;
        idx = (byte_addr - BASE) / 4;
        if (idx >= MW) return 32'h0;
        return 32'hA000_0000 + idx;
    endfunction

    // Offset of the k-th word of a burst for a request at byte address addr.
    function automatic int model_off(input logic [31:0] addr, input int k);
        int req_off;
        req_off = int'((addr / 4) % BW);
`ifdef CRITICAL_WORD_FIRST_EN
        return (req_off + k) % BW;
`else
        return k + 0 * req_off;
`endif
    endfunction

    // Issues a request at the next edge and checks every cycle up to and including the first idle
    // cycle after the burst. Call while the DUT is idle and before a rising edge. A second request
    // pulse (which must be ignored) is driven during cycle pulse_at; pass -1 for none.
    task automatic run_request(input logic [31:0] addr, input int pulse_at, input logic [31:0] pulse_addr);
        logic [31:0] base;
        logic [31:0] exp_data;
        int          exp_off;
        logic        exp_busy;
        logic        exp_dr;
        base        = addr - (addr % (4 * BW));
        ReadRequest = 1'b1;
        ReadAddress = addr;
        @(posedge clk);
        #1;
        for (int j = 0; j <= int'(T0 + BW); j++) begin
            ReadRequest = (j == pulse_at);
            ReadAddress = (j == pulse_at) ? pulse_addr : $urandom;
            exp_busy    = (j < int'(T0 + BW));
            exp_dr      = (j >= int'(T0)) && (j < int'(T0 + BW));
            @(negedge clk);
            total++;
            if (Busy !== exp_busy) begin
                bad++;
                $display("FAIL busy addr=%h cycle=%0d: got %b want %b", addr, j, Busy, exp_busy);
            end
            total++;
            if (DataReady !== exp_dr) begin
                bad++;
                $display("FAIL data_ready addr=%h cycle=%0d: got %b want %b", addr, j, DataReady, exp_dr);
            end
            if (exp_dr) begin
                exp_off  = model_off(addr, j - int'(T0));
                exp_data = model_word(base + 32'(exp_off * 4));
                total++;
                if (DataIn !== exp_data) begin
                    bad++;
                    $display("FAIL data_in addr=%h cycle=%0d: got %h want %h", addr, j, DataIn, exp_data);
                end
                total++;
                if (WordOffset !== 2'(exp_off)) begin
                    bad++;
                    $display("FAIL word_offset addr=%h cycle=%0d: got %0d want %0d", addr, j, WordOffset, exp_off);
                end
            end
            if (j < int'(T0 + BW)) begin
                @(posedge clk);
                #1;
            end
        end
        ReadRequest = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset       = 1'b1;
        ReadRequest = 1'b1;
        ReadAddress = 32'h0001_0000;
        @(posedge clk);
        #1;
        reset       = 1'b0;
        ReadRequest = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            total++;
            if ({Busy, DataReady, DataIn, WordOffset} !== 35'h0) begin
                bad++;
                $display("FAIL reset_idle cycle=%0d: got busy=%b dr=%b data=%h off=%0d want all zero",
                         i, Busy, DataReady, DataIn, WordOffset);
            end
        end
    endtask

    task automatic test_directed_block();
        @(negedge clk);
        run_request(32'h0001_0014, -1, 32'h0);
        run_request(32'h0001_0000, -1, 32'h0);
        run_request(32'h0001_0FFC, -1, 32'h0);
    endtask

    task automatic test_out_of_range();
        @(negedge clk);
        run_request(32'h0000_0040, -1, 32'h0);
        run_request(32'h0001_1000, -1, 32'h0);
        run_request(32'hFFFF_FFF8, -1, 32'h0);
    endtask

    task automatic test_ignored_request();
        @(negedge clk);
        run_request(32'h0001_0014, 2, 32'h0001_0020);
        run_request(32'h0001_0108, int'(T0) + 1, 32'h0001_0200);
    endtask

    // Requests issued at the earliest legal edge after each burst, from random addresses
    // straddling both ends of the backing store.
    task automatic test_back_to_back();
        logic [31:0] addr;
        @(negedge clk);
        for (int n = 0; n < 12; n++) begin
            case ($urandom_range(0, 3))
                0:       addr = $urandom;
                1:       addr = BASE - 32'($urandom_range(0, 64));
                2:       addr = BASE + MW * 4 - 32'h20 + 32'($urandom_range(0, 64));
                default: addr = BASE + 32'($urandom_range(0, MW * 4 - 1));
            endcase
            run_request(addr, -1, 32'h0);
        end
    endtask

    task automatic test_reset_mid_burst();
        int exp_off;
        @(negedge clk);
        ReadRequest = 1'b1;
        ReadAddress = 32'h0001_0034;
        @(posedge clk);
        #1;
        ReadRequest = 1'b0;
        repeat (T0 + 1) @(posedge clk);
        @(negedge clk);
        exp_off = model_off(32'h0001_0034, 1);
        total++;
        if (DataReady !== 1'b1 || WordOffset !== 2'(exp_off)) begin
            bad++;
            $display("FAIL mid_burst_word: got dr=%b off=%0d want dr=1 off=%0d", DataReady, WordOffset, exp_off);
        end
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < int'(BW) + 2; i++) begin
            @(negedge clk);
            total++;
            if (DataReady !== 1'b0 || Busy !== 1'b0) begin
                bad++;
                $display("FAIL after_abort cycle=%0d: got dr=%b busy=%b want dr=0 busy=0", i, DataReady, Busy);
            end
        end
        run_request(32'h0001_0000, -1, 32'h0);
    endtask

    initial begin
        for (int i = 0; i < int'(MW); i++) dut.mem[i] = 32'hA000_0000 + 32'(i);
        reset       = 1'b1;
        ReadRequest = 1'b0;
        ReadAddress = 32'h0;
        repeat (3) @(posedge clk);
        test_reset();
        test_directed_block();
        test_out_of_range();
        test_ignored_request();
        test_back_to_back();
        test_reset_mid_burst();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
